// File: rtl/keypad_scan_4x4.sv
// keypad_scan_4x4
//   Scans a 4x4 matrix keypad, debounces it and emits one key code per
//   physical press for the calculator display/operand stage.
//
// Parameters
//   SCAN_DIV     clk cycles per scan tick (>= 4)
//   DEBOUNCE_CNT consecutive matching tick samples to accept press/release (1..15)
//   CNT_W        width of the tick divider counter
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   col          column sense, active-low, asynchronous to clk
//   row          row drive, active-low, exactly one bit low
//   key_en       one-clk strobe when a debounced press is accepted
//   keyboard_num code of the last accepted key, changes only with key_en
//   key_held     high from the key_en cycle until the release is accepted
module keypad_scan_4x4 #(
  parameter int unsigned SCAN_DIV     = 20000,
  parameter int unsigned DEBOUNCE_CNT = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       key_en,
  output logic [3:0] keyboard_num,
  output logic       key_held
);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DIV_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [3:0]       DEB_TGT = 4'(DEBOUNCE_CNT);

  state_t           state;
  logic [3:0]       col_m;
  logic [3:0]       col_s;
  logic [CNT_W-1:0] div_cnt;
  logic             tick;
  logic [3:0]       deb_cnt;
  logic [3:0]       rel_cnt;
  logic [1:0]       lat_r;
  logic [1:0]       lat_c;
  logic [1:0]       row_idx;
  logic [1:0]       col_idx;
  logic             col_valid;

  // Key code lookup: row index r, column index c.
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  // Two-flop synchroniser; idle keypad reads all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_m <= '1;
      col_s <= '1;
    end else begin
      col_m <= col;
      col_s <= col_m;
    end
  end

  // Free-running scan tick divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_MAX) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  assign tick = (div_cnt == DIV_MAX);

  // Only a single low column is a valid key; none or chords are ignored.
  always_comb begin
    col_valid = 1'b1;
    col_idx   = 2'd0;
    case (col_s)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_valid = 1'b0;
    endcase
  end

  always_comb begin
    row_idx = 2'd0;
    case (row)
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= SCAN;
      row          <= 4'b1110;
      key_en       <= 1'b0;
      keyboard_num <= '0;
      key_held     <= 1'b0;
      deb_cnt      <= '0;
      rel_cnt      <= '0;
      lat_r        <= '0;
      lat_c        <= '0;
    end else begin
      key_en <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (col_valid) begin
              lat_r   <= row_idx;
              lat_c   <= col_idx;
              deb_cnt <= 4'd1;
              // A single-sample debounce accepts on the first qualifying tick.
              if (DEB_TGT == 4'd1) begin
                key_en       <= 1'b1;
                keyboard_num <= key_code(row_idx, col_idx);
                key_held     <= 1'b1;
                rel_cnt      <= '0;
                state        <= HOLD;
              end else begin
                state <= DEBOUNCE;
              end
            end else begin
              row <= {row[2:0], row[3]};
            end
          end

          DEBOUNCE: begin
            if (col_valid && (col_idx == lat_c)) begin
              deb_cnt <= deb_cnt + 4'd1;
              if ((deb_cnt + 4'd1) == DEB_TGT) begin
                key_en       <= 1'b1;
                keyboard_num <= key_code(lat_r, lat_c);
                key_held     <= 1'b1;
                rel_cnt      <= '0;
                state        <= HOLD;
              end
            end else begin
              row   <= {row[2:0], row[3]};
              state <= SCAN;
            end
          end

          HOLD: begin
            // Row stays frozen; only a sustained all-ones column ends the hold.
            if (col_s == 4'b1111) begin
              if ((rel_cnt + 4'd1) == DEB_TGT) begin
                rel_cnt  <= '0;
                key_held <= 1'b0;
                row      <= {row[2:0], row[3]};
                state    <= SCAN;
              end else begin
                rel_cnt <= rel_cnt + 4'd1;
              end
            end else begin
              rel_cnt <= '0;
            end
          end

          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_4x4.sv
module tb_keypad_scan_4x4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col;
  logic [3:0]  row;
  logic        key_en;
  logic [3:0]  keyboard_num;
  logic        key_held;

  logic [15:0] kp_mask;
  logic        ovr_en;
  logic [3:0]  ovr_col;
  logic [3:0]  kp_col;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0] r;
    logic [1:0] c;
    logic [3:0] code;
  } vec_t;

  vec_t tbl[16];

  always #5 clk = ~clk;

  // Passive keypad: a pressed key (r,c) pulls col[c] low while row[r] is driven low.
  always_comb begin
    kp_col = '1;
    for (int r = 0; r < 4; r++) begin
      if (!row[r]) begin
        for (int c = 0; c < 4; c++) begin
          if (kp_mask[r*4+c]) kp_col[c] = 1'b0;
        end
      end
    end
  end

  assign col = ovr_en ? ovr_col : kp_col;

  keypad_scan_4x4 #(
    .SCAN_DIV    (4),
    .DEBOUNCE_CNT(3),
    .CNT_W       (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .col         (col),
    .row         (row),
    .key_en      (key_en),
    .keyboard_num(keyboard_num),
    .key_held    (key_held)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] row_of(input int k);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << (k % 4));
  endfunction

  // Press one key, hold it, release it and check strobe, code, hold and release timing.
  task automatic press_release(input logic [1:0] r, input logic [1:0] c,
                               input logic [3:0] code, input int hold_clks,
                               input string tag);
    int en_cnt;
    en_cnt = 0;
    kp_mask = '0;
    kp_mask[{r, c}] = 1'b1;
    for (int i = 0; i < 80 + hold_clks; i++) begin
      step();
      if (key_en) en_cnt++;
    end
    check($sformatf("%s_en_count", tag), en_cnt, 1);
    check($sformatf("%s_code", tag), keyboard_num, code);
    check($sformatf("%s_held", tag), key_held, 1);
    check($sformatf("%s_row_frozen", tag), row, row_of(int'(r)));
    kp_mask = '0;
    en_cnt = 0;
    repeat (10) begin
      step();
      if (key_en) en_cnt++;
    end
    check($sformatf("%s_held_before_release", tag), key_held, 1);
    repeat (4) begin
      step();
      if (key_en) en_cnt++;
    end
    check($sformatf("%s_released", tag), key_held, 0);
    check($sformatf("%s_no_en_on_release", tag), en_cnt, 0);
    check($sformatf("%s_code_kept", tag), keyboard_num, code);
  endtask

  initial begin
    int en_cnt;
    int t;
    int first_k;

    tbl[0]  = '{2'd0, 2'd0, 4'h1};
    tbl[1]  = '{2'd0, 2'd1, 4'h2};
    tbl[2]  = '{2'd0, 2'd2, 4'h3};
    tbl[3]  = '{2'd0, 2'd3, 4'hA};
    tbl[4]  = '{2'd1, 2'd0, 4'h4};
    tbl[5]  = '{2'd1, 2'd1, 4'h5};
    tbl[6]  = '{2'd1, 2'd2, 4'h6};
    tbl[7]  = '{2'd1, 2'd3, 4'hB};
    tbl[8]  = '{2'd2, 2'd0, 4'h7};
    tbl[9]  = '{2'd2, 2'd1, 4'h8};
    tbl[10] = '{2'd2, 2'd2, 4'h9};
    tbl[11] = '{2'd2, 2'd3, 4'hC};
    tbl[12] = '{2'd3, 2'd0, 4'hE};
    tbl[13] = '{2'd3, 2'd1, 4'h0};
    tbl[14] = '{2'd3, 2'd2, 4'hF};
    tbl[15] = '{2'd3, 2'd3, 4'hD};

    rst     = 1'b1;
    kp_mask = '0;
    ovr_en  = 1'b0;
    ovr_col = '1;

    // Reset state and idle scanning.
    repeat (2) step();
    check("rst_row", row, 4'b1110);
    check("rst_key_en", key_en, 0);
    check("rst_num", keyboard_num, 0);
    check("rst_held", key_held, 0);
    @(negedge clk);
    rst = 1'b0;
    en_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (key_en) en_cnt++;
      check($sformatf("idle_row_k%0d", k), row, row_of(k / 4));
    end
    check("idle_no_en", en_cnt, 0);
    check("idle_num", keyboard_num, 0);

    // Every key through the full press/hold/release cycle.
    for (int i = 0; i < 16; i++) begin
      press_release(tbl[i].r, tbl[i].c, tbl[i].code, 0, $sformatf("key%0d", i));
    end

    // Bounce: column toggles on alternate ticks, never three matching samples.
    t = 0;
    while (row == 4'b1110 && t < 40) begin step(); t++; end
    while (row != 4'b1110 && t < 80) begin step(); t++; end
    check("bounce_align", (t < 80) ? 1 : 0, 1);
    ovr_en = 1'b1;
    en_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      ovr_col = 4'b1110;
      repeat (4) begin step(); if (key_en) en_cnt++; end
      ovr_col = 4'b1111;
      repeat (4) begin step(); if (key_en) en_cnt++; end
    end
    check("bounce_no_en", en_cnt, 0);
    check("bounce_held", key_held, 0);
    check("bounce_num", keyboard_num, 4'hD);
    check("bounce_row", row, 4'b1110);
    repeat (4) step();
    check("bounce_scan_resumed", row, 4'b1101);
    ovr_en = 1'b0;

    // Chord on row 0 (col 1001) is never reported.
    kp_mask = 16'h0006;
    en_cnt = 0;
    repeat (80) begin step(); if (key_en) en_cnt++; end
    check("chord_no_en", en_cnt, 0);
    check("chord_held", key_held, 0);
    t = 0;
    while (row != 4'b1101 && t < 20) begin step(); t++; end
    check("chord_scan_row1", row, 4'b1101);
    t = 0;
    while (row != 4'b1110 && t < 20) begin step(); t++; end
    check("chord_scan_row0", row, 4'b1110);
    kp_mask = '0;
    repeat (8) step();

    // Long hold gives one strobe; then a fresh key.
    press_release(2'd3, 2'd1, 4'h0, 200, "hold31");
    press_release(2'd2, 2'd0, 4'h7, 0, "next20");

    // Reset while a key is held, then re-detection after reset release.
    kp_mask = '0;
    kp_mask[{2'd1, 2'd1}] = 1'b1;
    t = 0;
    while (!key_held && t < 80) begin step(); t++; end
    check("rh_held_seen", key_held, 1);
    rst = 1'b1;
    #1;
    check("rh_row", row, 4'b1110);
    check("rh_held", key_held, 0);
    check("rh_num", keyboard_num, 0);
    check("rh_en", key_en, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    en_cnt = 0;
    first_k = 0;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (key_en) begin
        en_cnt++;
        if (first_k == 0) first_k = k;
      end
    end
    check("rh_redetect_count", en_cnt, 1);
    check("rh_redetect_latency", first_k, 16);
    check("rh_redetect_num", keyboard_num, 4'h5);
    check("rh_redetect_held", key_held, 1);
    kp_mask = '0;
    repeat (40) step();
    check("rh_release", key_held, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
